mux_serializer: RTL and testbench

- Parallel-to-serial sequencer. Accepts an N-bit word over a valid/ready handshake and sends it out one bit per beat.
- Each beat is produced by stepping the select input of an internal one-bit mux (N inputs, INVERT=0) across all N positions.
- The serial output has its own valid/ready handshake, so a slow downstream consumer can stall the sequence at any beat.
- Sits between word-wide datapath logic and single-wire links (SPI-style shifters, LED chains, debug taps).

---
 rtl/mux_serializer_if.sv | 28 ++
 rtl/mux_serializer.sv | 122 ++++++++++++
 tb/tb_mux_serializer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_serializer_if.sv
// Word-in / bit-out handshake bundle for mux_serializer.
// Ports: word side (i_data, i_valid, i_ready), bit side (o_bit, o_valid, o_ready, o_last),
// observability (select, busy). master = the surrounding logic, slave = the serializer.
interface mux_serializer_if #(
    parameter int N = 32
);
    localparam int W = $clog2(N);

    logic [N-1:0] i_data;
    logic         i_valid;
    logic         i_ready;
    logic         o_bit;
    logic         o_valid;
    logic         o_ready;
    logic         o_last;
    logic [W-1:0] select;
    logic         busy;

    modport master (
        output i_data, i_valid, o_ready,
        input  i_ready, o_bit, o_valid, o_last, select, busy
    );

    modport slave (
        input  i_data, i_valid, o_ready,
        output i_ready, o_bit, o_valid, o_last, select, busy
    );
endinterface

// File: rtl/mux_serializer.sv
// Purpose: serializes an N-bit word one bit per beat by stepping a 1-bit mux select.
// Latency: first bit valid the cycle after the word handshake; N beats per word, back-to-back capable.
// Backpressure: o_ready low freezes select/o_bit/o_last; i_ready rises only in IDLE or on the accepted last beat.
//
// Ports: clk, rst_n (synchronous, active-low), bus (mux_serializer_if.slave):
//   i_data/i_valid/i_ready word input, o_bit/o_valid/o_ready/o_last serial output,
//   select (current mux index), busy (word in flight).
// N must be a power of two and at least 2.
module mux_serializer #(
    parameter int N         = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_serializer_if.slave    bus
);
    localparam int W = $clog2(N);

    localparam logic [W-1:0] SEL_START = MSB_FIRST ? W'(N - 1) : W'(0);
    localparam logic [W-1:0] SEL_END   = MSB_FIRST ? W'(0)     : W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   data_reg;
    logic [N-1:0]   data_nxt;
    logic [W-1:0]   sel_reg;
    logic [W-1:0]   sel_nxt;
    logic [W-1:0]   sel_step;
    logic           mux_out;
    logic           last;
    logic           in_rdy;
    logic           out_vld;
    logic           busy_int;

    // One-bit N:1 mux, non-inverting.
    always_comb begin
        mux_out = data_reg[sel_reg];
    end

    // Stepping is only ever taken when the current beat is not the last,
    // so the select never wraps past the end index.
    always_comb begin
        sel_step = MSB_FIRST ? (sel_reg - W'(1)) : (sel_reg + W'(1));
    end

    always_comb begin
        last = (state == SEND) && (sel_reg == SEL_END);
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_reg;
        sel_nxt   = sel_reg;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        busy_int  = 1'b0;

        unique case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.i_valid) begin
                    data_nxt  = bus.i_data;
                    sel_nxt   = SEL_START;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_vld  = 1'b1;
                busy_int = 1'b1;
                if (bus.o_ready) begin
                    if (!last) begin
                        sel_nxt = sel_step;
                    end else begin
                        // Final beat accepted: the slot frees up this very cycle,
                        // letting a waiting word follow without a bubble.
                        in_rdy = 1'b1;
                        if (bus.i_valid) begin
                            data_nxt = bus.i_data;
                            sel_nxt  = SEL_START;
                        end else begin
                            state_nxt = IDLE;
                            sel_nxt   = '0;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
            end
        endcase

        // No word may be accepted while reset is being applied.
        if (!rst_n) begin
            in_rdy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_reg <= '0;
            sel_reg  <= '0;
        end else begin
            state    <= state_nxt;
            data_reg <= data_nxt;
            sel_reg  <= sel_nxt;
        end
    end

    assign bus.i_ready = in_rdy;
    assign bus.o_bit   = mux_out;
    assign bus.o_valid = out_vld;
    assign bus.o_last  = last;
    assign bus.select  = sel_reg;
    assign bus.busy    = busy_int;
endmodule

// File: tb/tb_mux_serializer.sv
module tb_mux_serializer;
    logic clk;
    logic rst_n;

    int checks;
    int failures;

    mux_serializer_if #(.N(8)) bus0 ();
    mux_serializer_if #(.N(8)) bus1 ();

    mux_serializer #(.N(8), .MSB_FIRST(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    mux_serializer #(.N(8), .MSB_FIRST(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         d;      // 0 = LSB-first DUT, 1 = MSB-first DUT
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ev;
        logic       eb;
        bit         cb;     // compare o_bit only when set
        logic       el;
        logic [2:0] es;
        logic       ebusy;
        logic       eir;
    } vec_t;

    function automatic vec_t mk(bit d, logic iv, logic [7:0] id, logic ordy,
                                logic ev, logic eb, bit cb, logic el,
                                logic [2:0] es, logic ebusy, logic eir);
        vec_t v;
        v.d = d; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ev = ev; v.eb = eb; v.cb = cb; v.el = el;
        v.es = es; v.ebusy = ebusy; v.eir = eir;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit d, input logic iv, input logic [7:0] id, input logic ordy);
        if (d == 1'b0) begin
            bus0.i_valid = iv; bus0.i_data = id; bus0.o_ready = ordy;
        end else begin
            bus1.i_valid = iv; bus1.i_data = id; bus1.o_ready = ordy;
        end
    endtask

    task automatic chk_out(input string tag, input bit d, input logic ev, input logic eb,
                           input bit cb, input logic el, input logic [2:0] es,
                           input logic ebusy, input logic eir);
        logic       v, b, l, bs, ir;
        logic [2:0] s;
        if (d == 1'b0) begin
            v = bus0.o_valid; b = bus0.o_bit; l = bus0.o_last;
            s = bus0.select; bs = bus0.busy; ir = bus0.i_ready;
        end else begin
            v = bus1.o_valid; b = bus1.o_bit; l = bus1.o_last;
            s = bus1.select; bs = bus1.busy; ir = bus1.i_ready;
        end
        chk({tag, ".o_valid"}, 32'(v), 32'(ev));
        if (cb) chk({tag, ".o_bit"}, 32'(b), 32'(eb));
        chk({tag, ".o_last"}, 32'(l), 32'(el));
        chk({tag, ".select"}, 32'(s), 32'(es));
        chk({tag, ".busy"}, 32'(bs), 32'(ebusy));
        chk({tag, ".i_ready"}, 32'(ir), 32'(eir));
    endtask

    vec_t vt[$];

    initial begin
        logic [7:0] w;
        int         vcount;

        checks   = 0;
        failures = 0;

        // LSB-first 8'hA5: bits 0..7 = 1,0,1,0,0,1,0,1
        vt.push_back(mk(0, 1, 8'hA5, 1, 0, 0, 0, 0, 3'd0, 0, 1));
        vt.push_back(mk(0, 0, 8'hA5, 1, 1, 1, 1, 0, 3'd0, 1, 0));
        vt.push_back(mk(0, 0, 8'hA5, 1, 1, 0, 1, 0, 3'd1, 1, 0));
        vt.push_back(mk(0, 0, 8'hA5, 1, 1, 1, 1, 0, 3'd2, 1, 0));
        vt.push_back(mk(0, 0, 8'hA5, 1, 1, 0, 1, 0, 3'd3, 1, 0));
        vt.push_back(mk(0, 0, 8'hA5, 1, 1, 0, 1, 0, 3'd4, 1, 0));
        vt.push_back(mk(0, 0, 8'hA5, 1, 1, 1, 1, 0, 3'd5, 1, 0));
        vt.push_back(mk(0, 0, 8'hA5, 1, 1, 0, 1, 0, 3'd6, 1, 0));
        vt.push_back(mk(0, 0, 8'hA5, 1, 1, 1, 1, 1, 3'd7, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 1));
        // MSB-first 8'hA5: bits 7..0 = 1,0,1,0,0,1,0,1
        vt.push_back(mk(1, 1, 8'hA5, 1, 0, 0, 0, 0, 3'd0, 0, 1));
        vt.push_back(mk(1, 0, 8'hA5, 1, 1, 1, 1, 0, 3'd7, 1, 0));
        vt.push_back(mk(1, 0, 8'hA5, 1, 1, 0, 1, 0, 3'd6, 1, 0));
        vt.push_back(mk(1, 0, 8'hA5, 1, 1, 1, 1, 0, 3'd5, 1, 0));
        vt.push_back(mk(1, 0, 8'hA5, 1, 1, 0, 1, 0, 3'd4, 1, 0));
        vt.push_back(mk(1, 0, 8'hA5, 1, 1, 0, 1, 0, 3'd3, 1, 0));
        vt.push_back(mk(1, 0, 8'hA5, 1, 1, 1, 1, 0, 3'd2, 1, 0));
        vt.push_back(mk(1, 0, 8'hA5, 1, 1, 0, 1, 0, 3'd1, 1, 0));
        vt.push_back(mk(1, 0, 8'hA5, 1, 1, 1, 1, 1, 3'd0, 1, 1));
        vt.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 3'd0, 0, 1));

        // ---- reset ----
        rst_n = 1'b0;
        drive(0, 0, 8'h00, 1);
        drive(1, 0, 8'h00, 1);
        @(negedge clk);
        @(negedge clk);
        chk_out("rst0", 0, 0, 0, 0, 0, 3'd0, 0, 0);
        chk_out("rst1", 1, 0, 0, 0, 0, 3'd0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_release.i_ready", 32'(bus0.i_ready), 32'd1);
        @(negedge clk);

        // ---- table-driven vectors ----
        foreach (vt[i]) begin
            drive(vt[i].d, vt[i].iv, vt[i].id, vt[i].ordy);
            #1;
            chk_out($sformatf("vec%0d", i), vt[i].d, vt[i].ev, vt[i].eb, vt[i].cb,
                    vt[i].el, vt[i].es, vt[i].ebusy, vt[i].eir);
            @(negedge clk);
        end

        // ---- stall: 8'hF0 LSB-first, o_ready low 3 cycles on beat 4 ----
        w = 8'hF0;
        vcount = 0;
        drive(0, 1, w, 1);
        #1 chk_out("stall_hs", 0, 0, 0, 0, 0, 3'd0, 0, 1);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, w, 1);
            #1 chk_out($sformatf("stall_b%0d", k + 1), 0, 1, w[k], 1, 0, 3'(k), 1, 0);
            if (bus0.o_valid) vcount++;
            @(negedge clk);
        end
        for (int s = 0; s < 3; s++) begin
            drive(0, 0, w, 0);
            #1 chk_out($sformatf("stall_hold%0d", s), 0, 1, 0, 1, 0, 3'd3, 1, 0);
            if (bus0.o_valid) vcount++;
            @(negedge clk);
        end
        for (int k = 3; k < 8; k++) begin
            drive(0, 0, w, 1);
            #1 chk_out($sformatf("stall_b%0d", k + 1), 0, 1, w[k], 1, (k == 7), 3'(k), 1, (k == 7));
            if (bus0.o_valid) vcount++;
            @(negedge clk);
        end
        chk("stall_total_cycles", 32'(vcount), 32'd11);
        #1 chk_out("stall_idle", 0, 0, 0, 0, 0, 3'd0, 0, 1);

        // ---- back-to-back: 8'h01 then 8'h80 with no gap ----
        drive(0, 1, 8'h01, 1);
        #1 chk_out("b2b_hs", 0, 0, 0, 0, 0, 3'd0, 0, 1);
        @(negedge clk);
        for (int b = 1; b <= 16; b++) begin
            logic eb;
            logic el;
            eb = (b == 1) || (b == 16);
            el = (b == 8) || (b == 16);
            drive(0, (b <= 8), 8'h80, 1);
            #1 chk_out($sformatf("b2b_b%0d", b), 0, 1, eb, 1, el, 3'((b - 1) % 8), 1, el);
            @(negedge clk);
        end
        drive(0, 0, 8'h00, 1);
        #1 chk_out("b2b_idle", 0, 0, 0, 0, 0, 3'd0, 0, 1);
        @(negedge clk);

        // ---- i_data changes during SEND have no effect ----
        drive(0, 1, 8'hFF, 1);
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            drive(0, 0, 8'h00, 1);
            #1 chk_out($sformatf("hold_b%0d", b + 1), 0, 1, 1, 1, (b == 7), 3'(b), 1, (b == 7));
            @(negedge clk);
        end

        // ---- reset mid-word ----
        drive(0, 1, 8'hFF, 1);
        @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            drive(0, 0, 8'hFF, 1);
            #1 chk_out($sformatf("mid_b%0d", b + 1), 0, 1, 1, 1, 0, 3'(b), 1, 0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        drive(0, 0, 8'hFF, 1);
        @(negedge clk);
        #1 chk_out("mid_rst1", 0, 0, 0, 0, 0, 3'd0, 0, 0);
        @(negedge clk);
        #1 chk_out("mid_rst2", 0, 0, 0, 0, 0, 3'd0, 0, 0);
        rst_n = 1'b1;
        drive(0, 1, 8'h00, 1);
        #1 chk_out("mid_release", 0, 0, 0, 0, 0, 3'd0, 0, 1);
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            drive(0, 0, 8'h00, 1);
            #1 chk_out($sformatf("post_b%0d", b + 1), 0, 1, 0, 1, (b == 7), 3'(b), 1, (b == 7));
            @(negedge clk);
        end
        #1 chk_out("post_idle", 0, 0, 0, 0, 0, 3'd0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
